// File: rtl/core_sequencer_pkg.sv
// Shared encodings for the demo core sequencer: ALU op codes, operand-source and
// write-enable values, FSM state encoding and instruction field positions.
package core_sequencer_pkg;

  localparam logic [2:0] OP_SUM  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_ADDI = 3'b100;
  localparam logic [2:0] OP_NOP  = 3'b101;
  localparam logic [2:0] OP_HALT = 3'b111;

  localparam logic R_TYPE     = 1'b1;
  localparam logic NOT_R_TYPE = 1'b0;
  localparam logic WR_EN      = 1'b1;
  localparam logic WR_DISEN   = 1'b0;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FETCH     = 3'd1;
  localparam logic [2:0] S_DECODE    = 3'd2;
  localparam logic [2:0] S_EXECUTE   = 3'd3;
  localparam logic [2:0] S_WRITEBACK = 3'd4;
  localparam logic [2:0] S_HALT      = 3'd5;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 13;
  localparam int RD_MSB  = 12;
  localparam int RD_LSB  = 11;
  localparam int RS1_MSB = 10;
  localparam int RS1_LSB = 9;
  localparam int RS2_MSB = 1;
  localparam int RS2_LSB = 0;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

endpackage

// File: rtl/control_unit.sv
// Opcode decoder: maps an opcode to ALU operation, operand-B source and
// register-write enable. Unknown opcodes (including HALT) decode to a no-op.
module control_unit
  import core_sequencer_pkg::*;
#(
  parameter int OP_WIDTH = 3
) (
  input  logic [OP_WIDTH-1:0] opcode,
  output logic [OP_WIDTH-1:0] alu_op,
  output logic                alu_src_type,
  output logic                reg_write
);

  always_comb begin
    alu_op       = OP_NOP;
    alu_src_type = NOT_R_TYPE;
    reg_write    = WR_DISEN;
    case (opcode)
      OP_SUM: begin alu_op = OP_SUM; alu_src_type = R_TYPE; reg_write = WR_EN; end
      OP_SUB: begin alu_op = OP_SUB; alu_src_type = R_TYPE; reg_write = WR_EN; end
      OP_AND: begin alu_op = OP_AND; alu_src_type = R_TYPE; reg_write = WR_EN; end
      OP_XOR: begin alu_op = OP_XOR; alu_src_type = R_TYPE; reg_write = WR_EN; end
      // Immediate add keeps write disabled until the datapath supports it.
      OP_ADDI: begin alu_op = OP_SUM; alu_src_type = NOT_R_TYPE; reg_write = WR_DISEN; end
      default: ;
    endcase
  end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer for the demo core. Owns the
// PC, instruction register, retired counter and the registered datapath controls.
module core_sequencer
  import core_sequencer_pkg::*;
#(
  parameter int OP_WIDTH    = 3,
  parameter int INSTR_WIDTH = 16,
  parameter int PC_WIDTH    = 8,
  parameter int RA_WIDTH    = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   run,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_ack,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic [RA_WIDTH-1:0]    rs1_addr,
  output logic [RA_WIDTH-1:0]    rs2_addr,
  output logic [RA_WIDTH-1:0]    rd_addr,
  output logic                   rf_we,
  output logic [OP_WIDTH-1:0]    alu_op,
  output logic                   alu_src_type,
  output logic [7:0]             imm,
  output logic [PC_WIDTH-1:0]    pc,
  output logic                   busy,
  output logic                   halted,
  output logic [7:0]             retired
);

  logic [2:0]             state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] ir_q, ir_d;
  logic [7:0]             retired_q, retired_d;
  logic [RA_WIDTH-1:0]    rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [7:0]             imm_q, imm_d;
  logic [OP_WIDTH-1:0]    alu_op_q, alu_op_d;
  logic                   alu_src_q, alu_src_d;
  logic                   reg_write_q, reg_write_d;
  logic                   halt_arm_q, halt_arm_d;

  logic [OP_WIDTH-1:0]    cu_alu_op;
  logic                   cu_alu_src;
  logic                   cu_reg_write;
  logic                   unused_ir_bit;

  // Bit 8 of the instruction word is reserved and carries no field.
  assign unused_ir_bit = ir_q[RS1_LSB-1];

  control_unit #(
    .OP_WIDTH(OP_WIDTH)
  ) u_control_unit (
    .opcode      (ir_q[OPC_MSB:OPC_LSB]),
    .alu_op      (cu_alu_op),
    .alu_src_type(cu_alu_src),
    .reg_write   (cu_reg_write)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    retired_d   = retired_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rd_d        = rd_q;
    imm_d       = imm_q;
    alu_op_d    = alu_op_q;
    alu_src_d   = alu_src_q;
    reg_write_d = reg_write_q;
    halt_arm_d  = halt_arm_q;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        rs1_d       = ir_q[RS1_MSB:RS1_LSB];
        rs2_d       = ir_q[RS2_MSB:RS2_LSB];
        rd_d        = ir_q[RD_MSB:RD_LSB];
        imm_d       = ir_q[IMM_MSB:IMM_LSB];
        alu_op_d    = cu_alu_op;
        alu_src_d   = cu_alu_src;
        reg_write_d = cu_reg_write;
        if (ir_q[OPC_MSB:OPC_LSB] == OP_HALT) begin
          state_d    = S_HALT;
          halt_arm_d = 1'b0;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        state_d = S_WRITEBACK;
      end
      S_WRITEBACK: begin
        pc_d      = pc_q + PC_WIDTH'(1);
        retired_d = retired_q + 8'd1;
        state_d   = run ? S_FETCH : S_IDLE;
      end
      S_HALT: begin
        // Resume needs a run low-then-high sequence; the HALT word itself is skipped.
        if (!run) begin
          halt_arm_d = 1'b1;
        end else if (halt_arm_q) begin
          halt_arm_d = 1'b0;
          pc_d       = pc_q + PC_WIDTH'(1);
          state_d    = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      ir_q        <= '0;
      retired_q   <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      imm_q       <= '0;
      alu_op_q    <= OP_NOP;
      alu_src_q   <= NOT_R_TYPE;
      reg_write_q <= WR_DISEN;
      halt_arm_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      retired_q   <= retired_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      imm_q       <= imm_d;
      alu_op_q    <= alu_op_d;
      alu_src_q   <= alu_src_d;
      reg_write_q <= reg_write_d;
      halt_arm_q  <= halt_arm_d;
    end
  end

  assign imem_req     = (state_q == S_FETCH);
  assign imem_addr    = pc_q;
  assign rf_we        = (state_q == S_WRITEBACK) && reg_write_q;
  assign rs1_addr     = rs1_q;
  assign rs2_addr     = rs2_q;
  assign rd_addr      = rd_q;
  assign alu_op       = alu_op_q;
  assign alu_src_type = alu_src_q;
  assign imm          = imm_q;
  assign pc           = pc_q;
  assign busy         = (state_q != S_IDLE) && (state_q != S_HALT);
  assign halted       = (state_q == S_HALT);
  assign retired      = retired_q;

endmodule
